vicii_composite_enc: RTL



---
 rtl/vicii_video_pkg.sv | 44 ++++
 rtl/vicii_sincos_lut.sv | 11 +
 rtl/vicii_composite_enc.sv | 124 ++++++++++++
 3 files changed

// File: rtl/vicii_video_pkg.sv
// Shared constants and types for the VIC-II composite video path: sine table,
// PAL burst phases, output width and the encoder's stage-1 record.
package vicii_video_pkg;

    localparam int CVBS_W   = 8;
    localparam int CVBS_MAX = (1 << CVBS_W) - 1;

    // Burst sits at 135 deg on even lines and 225 deg on odd lines (PAL swing).
    localparam logic [4:0] BURST_PHASE_EVEN = 5'd12;
    localparam logic [4:0] BURST_PHASE_ODD  = 5'd20;

    // round(127 * sin(2*pi*k/32)), k = 0..31
    localparam logic signed [7:0] SIN_Q7 [32] = '{
        8'sd0,    8'sd25,   8'sd49,   8'sd71,   8'sd90,   8'sd106,  8'sd117,  8'sd125,
        8'sd127,  8'sd125,  8'sd117,  8'sd106,  8'sd90,   8'sd71,   8'sd49,   8'sd25,
        8'sd0,   -8'sd25,  -8'sd49,  -8'sd71,  -8'sd90,  -8'sd106, -8'sd117, -8'sd125,
       -8'sd127, -8'sd125, -8'sd117, -8'sd106, -8'sd90,  -8'sd71,  -8'sd49,  -8'sd25
    };

    // SEL_SYNC is the all-zero code so a cleared pipeline outputs sync level.
    typedef enum logic [1:0] {
        SEL_SYNC   = 2'd0,
        SEL_BURST  = 2'd1,
        SEL_BLANK  = 2'd2,
        SEL_ACTIVE = 2'd3
    } sel_e;

    typedef struct packed {
        sel_e        sel;
        logic [4:0]  idx;
        logic [10:0] luma_term;
        logic        chroma_on;
    } stage1_t;

    function automatic logic [CVBS_W-1:0] clamp_cvbs(input logic signed [10:0] sum);
        if (sum < 0)
            return '0;
        else if (sum > 11'(CVBS_MAX))
            return CVBS_W'(CVBS_MAX);
        else
            return sum[CVBS_W-1:0];
    endfunction

endpackage

// File: rtl/vicii_sincos_lut.sv
// Combinational subcarrier sine lookup: 5-bit phase index to signed Q7 sample.
module vicii_sincos_lut
    import vicii_video_pkg::*;
(
    input  logic              [4:0] idx,
    output logic signed       [7:0] sin_q7
);

    assign sin_q7 = SIN_Q7[idx];

endmodule

// File: rtl/vicii_composite_enc.sv
// PAL composite encoder: subcarrier phase accumulator, V-axis line alternation,
// burst/sync insertion and a fixed two-register pipeline to the 8-bit DAC code.
module vicii_composite_enc
    import vicii_video_pkg::*;
#(
    parameter logic [23:0] PHASE_INC   = 24'h240000,
    parameter int          BLANK_LEVEL = 64,
    parameter int          LUMA_GAIN   = 4,
    parameter int          CHROMA_AMP  = 40,
    parameter int          BURST_AMP   = 24,
    parameter int          BURST_START = 40,
    parameter int          BURST_LEN   = 36
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        luma,
    input  logic [4:0]        chroma,
    input  logic              chroma_en,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              blank,
    output logic [CVBS_W-1:0] cvbs
);

    localparam int                BURST_END    = BURST_START + BURST_LEN;
    localparam logic signed [10:0] BLANK_S      = 11'(BLANK_LEVEL);
    localparam logic signed [8:0]  CHROMA_AMP_S = 9'(CHROMA_AMP);
    localparam logic signed [8:0]  BURST_AMP_S  = 9'(BURST_AMP);

    logic [23:0] acc;
    logic        odd;
    logic        hsync_d;
    logic [7:0]  bc;

    logic [4:0]  sp;
    logic [4:0]  eff_phase;
    logic [4:0]  pix_idx;
    logic [4:0]  burst_idx;
    logic        burst_win;
    stage1_t     s1_next;
    stage1_t     s1;

    // ---------------- stage 1: phase, index, selection ----------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        s1_next           = '0;
        sp                = acc[23:19];
        eff_phase         = odd ? (5'd0 - chroma) : chroma;
        pix_idx           = sp + eff_phase;
        burst_idx         = sp + (odd ? BURST_PHASE_ODD : BURST_PHASE_EVEN);
        burst_win         = (int'(bc) >= BURST_START) && (int'(bc) < BURST_END);
        s1_next.luma_term = 11'(luma) * 11'(LUMA_GAIN);
        s1_next.chroma_on = chroma_en;

        if (hsync || vsync) begin
            s1_next.sel = SEL_SYNC;
        end else if (blank && burst_win) begin
            s1_next.sel = SEL_BURST;
            s1_next.idx = burst_idx;
        end else if (blank) begin
            s1_next.sel = SEL_BLANK;
        end else begin
            s1_next.sel = SEL_ACTIVE;
            s1_next.idx = pix_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            odd     <= 1'b0;
            hsync_d <= 1'b0;
            bc      <= '0;
            s1      <= '0;
        end else begin
            // NOTE: non-blocking so every register here samples pre-edge values.
            acc     <= acc + PHASE_INC;
            hsync_d <= hsync;
            if (hsync && !hsync_d)
                odd <= ~odd;
            // vsync deliberately leaves the burst counter running.
            if (hsync)
                bc <= '0;
            else if (bc != 8'hFF)
                bc <= bc + 8'd1;
            s1 <= s1_next;
        end
    end

    // ---------------- stage 2: lookup, scale, sum, clamp ----------------
    logic signed [7:0]  sin_val;
    logic signed [8:0]  amp;
    logic signed [16:0] prod;
    logic signed [10:0] scaled;
    logic signed [10:0] sum;

    vicii_sincos_lut u_lut (
        .idx    (s1.idx),
        .sin_q7 (sin_val)
    );

    always_comb begin
        amp    = (s1.sel == SEL_BURST) ? BURST_AMP_S : CHROMA_AMP_S;
        prod   = sin_val * amp;
        // Arithmetic shift floors toward minus infinity, not toward zero.
        scaled = 11'(prod >>> 7);
        sum    = '0;
        case (s1.sel)
            SEL_BURST:  sum = BLANK_S + scaled;
            SEL_BLANK:  sum = BLANK_S;
            SEL_ACTIVE: sum = BLANK_S + $signed(s1.luma_term)
                              + (s1.chroma_on ? scaled : 11'sd0);
            default:    sum = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cvbs <= '0;
        else
            cvbs <= clamp_cvbs(sum);
    end

endmodule
